// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   arbStateT : arbiter FSM states (IDLE, ACCESS, RESP)
//   GNT_*     : grant encoding (none / instruction fetch / data access)
//   CNT_W     : width of the latency and streak counters
//   satInc    : saturating increment used by the starvation streak counter
package mips_mem_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbStateT;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                                input logic [CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between instruction fetch and data access.
//   ifReq  in  fetch request pending
//   dmReq  in  data request pending
//   streak in  consecutive data grants made while a fetch was waiting
//   grant  out GNT_NONE / GNT_IF / GNT_DM
// Data access normally wins; once the streak reaches STARVE_MAX a waiting fetch is forced through.
module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             ifReq,
    input  logic             dmReq,
    input  logic [CNT_W-1:0] streak,
    output logic [1:0]       grant
);

    localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_MAX);

    always_comb begin
        grant = GNT_NONE;
        if (ifReq && (!dmReq || streak >= StarveLim)) begin
            grant = GNT_IF;
        end else if (dmReq) begin
            grant = GNT_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between the IF stage (fetch) and MEM stage (load/store).
// One requester is granted at a time; the port is driven for LATENCY cycles, then a one-cycle
// ack is returned with the read data.
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request and byte address
//   if_ack/if_rdata                fetch completion pulse and instruction (held after ack)
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, store data
//   dm_ack/dm_rdata                data completion pulse and load data (held after ack)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   stall_if/stall_mem             request pending and not yet acked (to hazard logic)
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_MAX);

    arbStateT         stateQ, stateD;
    logic [1:0]       grantQ, grantD;
    logic [1:0]       pickGrant;
    logic [CNT_W-1:0] streakQ, streakD;
    logic [CNT_W-1:0] latCntQ, latCntD;
    logic [31:0]      addrQ, addrD;
    logic             weQ, weD;
    logic [31:0]      wdataQ, wdataD;
    logic [31:0]      ifRdataQ, ifRdataD;
    logic [31:0]      dmRdataQ, dmRdataD;

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) uPick (
        .ifReq (if_req),
        .dmReq (dm_req),
        .streak(streakQ),
        .grant (pickGrant)
    );

    always_comb begin
        stateD   = stateQ;
        grantD   = grantQ;
        streakD  = streakQ;
        latCntD  = latCntQ;
        addrD    = addrQ;
        weD      = weQ;
        wdataD   = wdataQ;
        ifRdataD = ifRdataQ;
        dmRdataD = dmRdataQ;

        case (stateQ)
            IDLE: begin
                if (pickGrant != GNT_NONE) begin
                    stateD  = ACCESS;
                    grantD  = pickGrant;
                    latCntD = '0;
                    if (pickGrant == GNT_DM) begin
                        addrD   = dm_addr;
                        weD     = dm_we;
                        wdataD  = dm_wdata;
                        // Only data grants that overtook a waiting fetch count toward starvation.
                        streakD = if_req ? satInc(streakQ, StarveLim) : '0;
                    end else begin
                        addrD   = if_addr;
                        weD     = 1'b0;
                        wdataD  = '0;
                        streakD = '0;
                    end
                end
            end
            ACCESS: begin
                if (latCntQ == LastCnt) begin
                    stateD = RESP;
                    // Read data is valid on the final access cycle only.
                    if (grantQ == GNT_IF) begin
                        ifRdataD = mem_rdata;
                    end else if (!weQ) begin
                        dmRdataD = mem_rdata;
                    end
                end else begin
                    latCntD = latCntQ + 1'b1;
                end
            end
            RESP: begin
                stateD = IDLE;
                grantD = GNT_NONE;
            end
            default: begin
                stateD = IDLE;
                grantD = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= IDLE;
            grantQ   <= GNT_NONE;
            streakQ  <= '0;
            latCntQ  <= '0;
            addrQ    <= '0;
            weQ      <= 1'b0;
            wdataQ   <= '0;
            ifRdataQ <= '0;
            dmRdataQ <= '0;
        end else begin
            stateQ   <= stateD;
            grantQ   <= grantD;
            streakQ  <= streakD;
            latCntQ  <= latCntD;
            addrQ    <= addrD;
            weQ      <= weD;
            wdataQ   <= wdataD;
            ifRdataQ <= ifRdataD;
            dmRdataQ <= dmRdataD;
        end
    end

    // Port enables decode straight from the state register so reset drops them immediately.
    assign mem_en    = (stateQ == ACCESS);
    assign mem_we    = mem_en & weQ;
    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;

    assign if_ack    = (stateQ == RESP) && (grantQ == GNT_IF);
    assign dm_ack    = (stateQ == RESP) && (grantQ == GNT_DM);
    assign if_rdata  = ifRdataQ;
    assign dm_rdata  = dmRdataQ;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int Lat = 2;
    localparam int Sm  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(
        .LATENCY   (Lat),
        .STARVE_MAX(Sm)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    // Memory: 256 words indexed by addr[9:2]; data only valid on the LATENCY-th enabled cycle.
    logic [31:0] memArr [0:255];
    bit          memInit = 1'b0;
    int          enRun = 0;
    logic        plEn = 1'b0;
    logic [7:0]  plIdx = 8'd0;
    logic [31:0] plVal = 32'd0;

    assign mem_rdata = (mem_en && enRun == Lat - 1) ? memArr[mem_addr[9:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 256; i++) memArr[i] <= 32'h9E37_79B9 * 32'(i + 1);
            memInit <= 1'b1;
        end
        if (plEn) memArr[plIdx] <= plVal;
        if (mem_en && mem_we) memArr[mem_addr[9:2]] <= mem_wdata;
        enRun <= mem_en ? enRun + 1 : 0;
    end

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one granted transfer occupies cycles start..start+Lat+1.
    bit          busy = 1'b0, gDm = 1'b0, gWe = 1'b0;
    int          gStart = 0, streak = 0;
    logic [31:0] gAddr = '0, gWdata = '0, capVal = '0, ifRdE = '0, dmRdE = '0;
    bit          mIfAck = 1'b0, mDmAck = 1'b0;

    task automatic modelStep();
        int k;
        bit eMemEn, eMemWe, eIfAck, eDmAck, pickIf;
        cyc++;
        if (rst) begin
            busy = 1'b0; streak = 0; ifRdE = '0; dmRdE = '0;
            mIfAck = 1'b0; mDmAck = 1'b0;
            chk("rst mem_en", mem_en, 0);
            chk("rst mem_we", mem_we, 0);
            chk("rst if_ack", if_ack, 0);
            chk("rst dm_ack", dm_ack, 0);
            chk("rst mem_addr", mem_addr, 0);
            chk("rst mem_wdata", mem_wdata, 0);
            chk("rst if_rdata", if_rdata, 0);
            chk("rst dm_rdata", dm_rdata, 0);
            return;
        end
        k = busy ? cyc - gStart : -1;
        eMemEn = busy && k >= 1 && k <= Lat;
        eMemWe = eMemEn && gWe;
        if (busy && k == Lat) capVal = memArr[gAddr[9:2]];
        eIfAck = busy && k == Lat + 1 && !gDm;
        eDmAck = busy && k == Lat + 1 && gDm;
        if (eIfAck) ifRdE = capVal;
        if (eDmAck && !gWe) dmRdE = capVal;

        chk("mem_en", mem_en, eMemEn);
        chk("mem_we", mem_we, eMemWe);
        chk("if_ack", if_ack, eIfAck);
        chk("dm_ack", dm_ack, eDmAck);
        chk("stall_if", stall_if, if_req & ~eIfAck);
        chk("stall_mem", stall_mem, dm_req & ~eDmAck);
        chk("if_rdata", if_rdata, ifRdE);
        chk("dm_rdata", dm_rdata, dmRdE);
        if (eMemEn) chk("mem_addr", mem_addr, gAddr);
        if (eMemWe) chk("mem_wdata", mem_wdata, gWdata);
        mIfAck = eIfAck;
        mDmAck = eDmAck;

        if (busy && k == Lat + 1) begin
            busy = 1'b0;
        end else if (!busy && (if_req || dm_req)) begin
            pickIf = if_req && (!dm_req || streak == Sm);
            gDm    = !pickIf;
            gAddr  = pickIf ? if_addr : dm_addr;
            gWe    = !pickIf && dm_we;
            gWdata = dm_wdata;
            gStart = cyc;
            busy   = 1'b1;
            if (pickIf || !if_req) streak = 0;
            else streak = (streak + 1 > Sm) ? Sm : streak + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        modelStep();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte   got [6];
        int    nGot;
        string expSeq;

        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h0;

        // Reset held three cycles with both requests up; preload directed data meanwhile.
        plEn = 1'b1; plIdx = 8'd4; plVal = 32'h8C22_0004;
        tick(); chk("reset if_ack", if_ack, 0); chk("reset stall_if", stall_if, 1);
        next(); plIdx = 8'd64; plVal = 32'h1234_5678;
        tick(); chk("reset mem_en", mem_en, 0);
        next(); plEn = 1'b0;
        tick(); chk("reset dm_ack", dm_ack, 0);
        next(); rst = 1'b0;

        // Simultaneous: load wins, then the fetch.
        tick(); chk("sim c0 mem_en", mem_en, 0);
        next(); tick(); chk("sim c1 mem_en", mem_en, 1); chk("sim c1 mem_addr", mem_addr, 32'h100);
        next(); tick(); chk("sim c2 stall_if", stall_if, 1);
        next(); tick(); chk("sim c3 dm_ack", dm_ack, 1);
        chk("sim c3 dm_rdata", dm_rdata, 32'h1234_5678); chk("sim c3 if_ack", if_ack, 0);
        next(); dm_req = 1'b0;
        tick(); chk("sim c4 mem_en", mem_en, 0);
        next(); tick(); chk("sim c5 mem_addr", mem_addr, 32'h10); chk("sim c5 mem_we", mem_we, 0);
        next(); tick();
        next(); tick(); chk("sim c7 if_ack", if_ack, 1); chk("sim c7 if_rdata", if_rdata, 32'h8C22_0004);
        next(); if_req = 1'b0;
        tick();

        // Store.
        next(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        tick();
        next(); tick(); chk("st c1 mem_we", mem_we, 1); chk("st c1 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st c1 mem_addr", mem_addr, 32'h200);
        next(); tick(); chk("st c2 mem_we", mem_we, 1);
        next(); tick(); chk("st c3 dm_ack", dm_ack, 1); chk("st c3 dm_rdata", dm_rdata, 32'h1234_5678);
        next(); dm_req = 1'b0; dm_we = 1'b0;
        tick(); chk("st committed", memArr[128], 32'hDEAD_BEEF);

        // Lone fetch.
        next(); if_req = 1'b1; if_addr = 32'h10;
        tick(); chk("lf c0 stall_if", stall_if, 1); chk("lf c0 mem_en", mem_en, 0);
        next(); tick(); chk("lf c1 mem_en", mem_en, 1); chk("lf c1 mem_addr", mem_addr, 32'h10);
        next(); tick(); chk("lf c2 stall_if", stall_if, 1);
        next(); tick(); chk("lf c3 if_ack", if_ack, 1); chk("lf c3 if_rdata", if_rdata, 32'h8C22_0004);
        chk("lf c3 stall_if", stall_if, 0);
        next(); if_req = 1'b0;
        tick();

        // Starvation: fresh streak, both requesters held high continuously.
        next(); rst = 1'b1;
        tick();
        next(); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        nGot = 0;
        for (int c = 0; c < 60 && nGot < 6; c++) begin
            tick();
            if (dm_ack && nGot < 6) begin got[nGot] = "D"; nGot++; end
            if (if_ack && nGot < 6) begin got[nGot] = "I"; nGot++; end
            if (nGot < 6) begin
                next();
                if (mDmAck) dm_addr = dm_addr + 32'd4;
                if (mIfAck) if_addr = if_addr + 32'd4;
            end
        end
        compared++;
        if (nGot != 6) begin
            mismatched++;
            $display("FAIL starve ack count: got %0d acks, expected 6 within 60 cycles", nGot);
        end
        expSeq = "DDDDID";
        for (int i = 0; i < nGot; i++) chk("starve grant order", 32'(got[i]), 32'(expSeq[i]));
        next(); if_req = 1'b0; dm_req = 1'b0;
        tick();

        // Reset in the first access cycle of a fetch.
        next(); if_req = 1'b1; if_addr = 32'h10;
        tick();
        next(); #2 rst = 1'b1;
        #1 chk("midrst async mem_en", mem_en, 0);
        tick();
        next(); rst = 1'b0;
        tick(); chk("midrst c2 if_ack", if_ack, 0); chk("midrst c2 mem_en", mem_en, 0);
        next(); tick(); chk("midrst c3 mem_en", mem_en, 1); chk("midrst c3 mem_addr", mem_addr, 32'h10);
        next(); tick();
        next(); tick(); chk("midrst c5 if_ack", if_ack, 1); chk("midrst c5 if_rdata", if_rdata, 32'h8C22_0004);
        next(); if_req = 1'b0;
        tick();

        // Randomized traffic with fetch flushes and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            next();
            rst = ($urandom_range(0, 149) == 0);
            if (!if_req || mIfAck) begin
                if ($urandom_range(0, 2) != 0) begin
                    if_req = 1'b1;
                    if_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) << 2;
                end else begin
                    if_req = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!dm_req || mDmAck) begin
                if ($urandom_range(0, 2) != 0) begin
                    dm_req = 1'b1;
                    dm_we = 1'($urandom_range(0, 1));
                    dm_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) << 2;
                    dm_wdata = $urandom;
                end else begin
                    dm_req = 1'b0;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one shared single-port unified memory between two requesters of the pipelined MIPS core: instruction fetch (IF stage) and data access (MEM stage, load/store).
- Grants one requester at a time and drives the memory port for a fixed access latency.
- Returns a one-cycle ack with read data, and raises stall outputs so the hazard logic can freeze PC/IFID or the later stages.

Parameters:
- LATENCY, 2, memory cycles from issue to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address; stable while if_req=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetched instruction; valid while if_ack=1, held afterwards.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=store, 0=load; stable while dm_req=1.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle data completion pulse.
- dm_rdata  out  32  load data; valid while dm_ack=1.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  dm_req & ~dm_ack (combinational).

Behaviour:
- **Reset values** (rst=1, immediately, any state): state=IDLE; mem_en, mem_we, if_ack and dm_ack are 0; mem_addr, mem_wdata, if_rdata and dm_rdata are 0; grant=NONE; streak counter=0; latency counter=0.
- **IDLE**
  - No request: stay.
  - Otherwise pick a winner, latch its addr/we/wdata into port registers, go to ACCESS.
  - Priority: dm wins over if, except when streak==STARVE_MAX and if_req=1; then if wins.
- **ACCESS** (exactly LATENCY cycles)
  - mem_en=1 throughout; mem_addr/mem_we/mem_wdata hold the latched values.
  - mem_we=1 only for a dm store; always 0 for fetch.
  - Counter runs 0..LATENCY-1.
  - On the last cycle, mem_rdata is captured: into if_rdata for a fetch, into dm_rdata for a load, nothing for a store.
  - Next state is RESP.
- **RESP** (1 cycle)
  - mem_en=0, mem_we=0.
  - The granted requester's ack is 1; the other ack is 0.
  - Next state is IDLE.
- **Latency:** a request seen in IDLE at cycle 0 acks at cycle LATENCY+1. The minimum gap between grants is LATENCY+2 cycles.
- **Back-to-back:** a requester that keeps req=1 in the cycle after its ack is making a new request (new addr/data presented then). It is arbitrated in that IDLE cycle.
- **Streak counter**
  - Increments, saturating at STARVE_MAX, on each dm grant made while if_req=1.
  - Clears on any if grant, or on a dm grant made while if_req=0.
- **Request withdrawal during ACCESS** (e.g. branch flush dropping if_req): no abort. The access completes and the ack still pulses; stores are always committed.
- **Simultaneous events**
  - Both requests in IDLE: resolved by the priority rule above.
  - A request arriving during ACCESS/RESP waits and is stalled via stall_*.
- **Reset mid-access:** the access is abandoned, no ack is produced, and the memory port is deasserted asynchronously.
- **Width rules:** addresses pass through unmodified (no alignment check). The counters are 4-bit.

Decomposition:
- Shared package mips_mem_pkg contains:
  - state enum {IDLE, ACCESS, RESP};
  - grant encoding GNT_NONE=2'b00, GNT_IF=2'b01, GNT_DM=2'b10;
  - counter width constant CNT_W=4.
- Sub-module mem_arb_pick: combinational winner selection from (if_req, dm_req, streak, STARVE_MAX) producing a grant code. The FSM, counters and port registers stay in mem_port_arbiter.

Test Plan (all with LATENCY=2, STARVE_MAX=4):
1. **Reset:** assert rst for 3 cycles with both reqs high -> all outputs 0, no mem_en; first grant occurs in the cycle after rst falls.
2. **Lone fetch:** if_req=1, if_addr=0x00000010 at cycle 0, mem_rdata=0x8C220004 -> mem_en=1 with mem_addr=0x10 in cycles 1-2; if_ack=1 and if_rdata=0x8C220004 in cycle 3; stall_if=1 in cycles 0-2.
3. **Simultaneous:** if_req and dm_req (load, addr 0x100, mem_rdata 0x12345678) both at cycle 0 -> dm_ack in cycle 3 with dm_rdata=0x12345678; if granted in cycle 4; if_ack in cycle 7.
4. **Store:** dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF in cycles 1-2; dm_ack in cycle 3; dm_rdata unchanged.
5. **Starvation:** dm_req held high continuously with if_req high -> four dm acks, then the fifth grant goes to if; streak clears and dm is granted next.
6. **Reset mid-access:** rst pulsed in cycle 1 of a fetch -> mem_en drops within the same cycle and no if_ack follows; with if_req still high, the fetch restarts cleanly after rst release.
